// File: rtl/branch_predictor_unit.sv
// BTB + PHT branch predictor: zero-latency lookup at IF, resolution and table update from EX.
// Optional build macro GSHARE_EN folds a global history register into the PHT index.
module branch_predictor_unit #(
  parameter  int unsigned BTB_ENTRIES = 32,
  parameter  int unsigned CNT_WIDTH   = 2,
  parameter  int unsigned GHR_WIDTH   = 5,
  localparam int unsigned IDX_W       = $clog2(BTB_ENTRIES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      IF_pc,
  output logic             pred_taken,
  output logic [31:0]      pred_pc,
  output logic [IDX_W-1:0] pred_idx,
  input  logic             EX_valid,
  input  logic             EX_is_ctrl,
  input  logic             EX_is_branch,
  input  logic [31:0]      EX_pc,
  input  logic [31:0]      EX_target,
  input  logic             EX_taken,
  input  logic [31:0]      EX_pred_pc,
  input  logic [IDX_W-1:0] EX_pht_idx,
  output logic             mispredict,
  output logic [31:0]      redirect_pc,
  output logic             flush_IF_ID,
  output logic             flush_ID_EX
);

  localparam int unsigned          TAG_W       = 30 - IDX_W;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX     = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_WEAK_T  = CNT_ONE << (CNT_WIDTH - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_WEAK_NT = CNT_WEAK_T - CNT_ONE;

  if (BTB_ENTRIES < 4 || BTB_ENTRIES > 1024 || (BTB_ENTRIES & (BTB_ENTRIES - 1)) != 0)
  begin : g_bad_entries
    $error("BTB_ENTRIES must be a power of two in 4..1024");
  end
  if (CNT_WIDTH < 1 || CNT_WIDTH > 4) begin : g_bad_cnt
    $error("CNT_WIDTH must be in 1..4");
  end
  if (GHR_WIDTH < 1 || GHR_WIDTH > IDX_W) begin : g_bad_ghr
    $error("GHR_WIDTH must be in 1..log2(BTB_ENTRIES)");
  end

  logic                 r_valid  [BTB_ENTRIES];
  logic [TAG_W-1:0]     r_tag    [BTB_ENTRIES];
  logic [31:0]          r_target [BTB_ENTRIES];
  logic                 r_uncond [BTB_ENTRIES];
  logic [CNT_WIDTH-1:0] r_cnt    [BTB_ENTRIES];

  logic [IDX_W-1:0]     w_if_idx;
  logic [TAG_W-1:0]     w_if_tag;
  logic                 w_hit;
  logic [31:0]          w_if_pc_inc;
  logic [IDX_W-1:0]     w_ex_idx;
  logic [TAG_W-1:0]     w_ex_tag;
  logic                 w_upd;
  logic                 w_ex_alloc;
  logic [31:0]          w_actual;
  logic [CNT_WIDTH-1:0] w_cnt_cur;
  logic [CNT_WIDTH-1:0] w_cnt_next;
  logic                 w_unused_bits;

  assign w_unused_bits = ^{IF_pc[1:0], EX_pc[1:0]};

  // Lookup side (IF)
  assign w_if_idx    = IF_pc[IDX_W+1:2];
  assign w_if_tag    = IF_pc[31:IDX_W+2];
  assign w_if_pc_inc = IF_pc + 32'd4;
  assign w_hit       = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);

`ifdef GSHARE_EN
  logic [GHR_WIDTH-1:0] r_ghr;

  assign pred_idx = w_if_idx ^ IDX_W'(r_ghr);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ghr <= '0;
    end else if (EX_valid && EX_is_branch) begin
      r_ghr <= (r_ghr << 1) | GHR_WIDTH'(EX_taken);
    end
  end
`else
  assign pred_idx = w_if_idx;
`endif

  assign pred_taken = w_hit && (r_uncond[w_if_idx] || r_cnt[pred_idx][CNT_WIDTH-1]);
  assign pred_pc    = pred_taken ? r_target[w_if_idx] : w_if_pc_inc;

  // Resolution side (EX); a taken prediction on a non-control instruction falls out naturally.
  assign w_actual    = EX_taken ? EX_target : (EX_pc + 32'd4);
  assign mispredict  = EX_valid && (w_actual != EX_pred_pc);
  assign redirect_pc = mispredict ? w_actual : w_if_pc_inc;
  assign flush_IF_ID = mispredict;
  assign flush_ID_EX = mispredict;

  assign w_ex_idx   = EX_pc[IDX_W+1:2];
  assign w_ex_tag   = EX_pc[31:IDX_W+2];
  assign w_upd      = EX_valid && EX_is_ctrl;
  assign w_ex_alloc = !(r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag));

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_cnt_cur  = r_cnt[EX_pht_idx];
    w_cnt_next = w_cnt_cur;
    if (w_ex_alloc) begin
      w_cnt_next = EX_taken ? CNT_WEAK_T : CNT_WEAK_NT;
    end else if (EX_taken) begin
      if (w_cnt_cur != CNT_MAX) w_cnt_next = w_cnt_cur + CNT_ONE;
    end else if (w_cnt_cur != '0) begin
      w_cnt_next = w_cnt_cur - CNT_ONE;
    end
  end

  // NOTE: only valid bits and counters need reset; tag/target/uncond are masked by valid, so
  // they sit in a reset-free array that can map onto plain RAM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(BTB_ENTRIES); i++) begin
        r_valid[i] <= 1'b0;
        r_cnt[i]   <= CNT_WEAK_NT;
      end
    end else if (w_upd) begin
      r_valid[w_ex_idx] <= 1'b1;
      if (EX_is_branch) r_cnt[EX_pht_idx] <= w_cnt_next;
    end
  end

  // NOTE: state updates use non-blocking assignments so same-cycle lookups see pre-update contents.
  always_ff @(posedge clk) begin
    if (w_upd) begin
      r_tag[w_ex_idx]    <= w_ex_tag;
      r_uncond[w_ex_idx] <= !EX_is_branch;
      if (EX_taken) r_target[w_ex_idx] <= EX_target;
    end
  end

endmodule

// File: tb/tb_branch_predictor_unit.sv
// Directed bench for branch_predictor_unit (default build: 32 entries, 2-bit counters, no gshare).
// Expected outputs are queued when a step is driven and popped when the outputs are sampled.
module tb_branch_predictor_unit;

  localparam int IDX_W = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic [31:0]      IF_pc;
  logic             pred_taken;
  logic [31:0]      pred_pc;
  logic [IDX_W-1:0] pred_idx;
  logic             EX_valid;
  logic             EX_is_ctrl;
  logic             EX_is_branch;
  logic [31:0]      EX_pc;
  logic [31:0]      EX_target;
  logic             EX_taken;
  logic [31:0]      EX_pred_pc;
  logic [IDX_W-1:0] EX_pht_idx;
  logic             mispredict;
  logic [31:0]      redirect_pc;
  logic             flush_IF_ID;
  logic             flush_ID_EX;

  branch_predictor_unit #(
    .BTB_ENTRIES(32),
    .CNT_WIDTH  (2),
    .GHR_WIDTH  (5)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .IF_pc       (IF_pc),
    .pred_taken  (pred_taken),
    .pred_pc     (pred_pc),
    .pred_idx    (pred_idx),
    .EX_valid    (EX_valid),
    .EX_is_ctrl  (EX_is_ctrl),
    .EX_is_branch(EX_is_branch),
    .EX_pc       (EX_pc),
    .EX_target   (EX_target),
    .EX_taken    (EX_taken),
    .EX_pred_pc  (EX_pred_pc),
    .EX_pht_idx  (EX_pht_idx),
    .mispredict  (mispredict),
    .redirect_pc (redirect_pc),
    .flush_IF_ID (flush_IF_ID),
    .flush_ID_EX (flush_ID_EX)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             pt;
    logic [31:0]      ppc;
    logic [IDX_W-1:0] idx;
    logic             mp;
    logic [31:0]      rpc;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    total = 0;
  int    bad   = 0;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", name, obs, expv);
    end
  endtask

  task automatic push_exp(input string tag, input logic pt, input logic [31:0] ppc,
                          input logic [IDX_W-1:0] idx, input logic mp, input logic [31:0] rpc);
    exp_t e;
    e.pt  = pt;
    e.ppc = ppc;
    e.idx = idx;
    e.mp  = mp;
    e.rpc = rpc;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic compare_out();
    exp_t  e;
    string t;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check({t, ".pred_taken"},  32'(pred_taken),  32'(e.pt));
      check({t, ".pred_pc"},     pred_pc,          e.ppc);
      check({t, ".pred_idx"},    32'(pred_idx),    32'(e.idx));
      check({t, ".mispredict"},  32'(mispredict),  32'(e.mp));
      check({t, ".redirect_pc"}, redirect_pc,      e.rpc);
      check({t, ".flush_IF_ID"}, 32'(flush_IF_ID), 32'(e.mp));
      check({t, ".flush_ID_EX"}, 32'(flush_ID_EX), 32'(e.mp));
    end
  endtask

  task automatic drive_ex(input logic v, input logic ctrl, input logic br, input logic [31:0] pc,
                          input logic [31:0] tgt, input logic tk, input logic [31:0] ppc);
    EX_valid     = v;
    EX_is_ctrl   = ctrl;
    EX_is_branch = br;
    EX_pc        = pc;
    EX_target    = tgt;
    EX_taken     = tk;
    EX_pred_pc   = ppc;
    EX_pht_idx   = pc[IDX_W+1:2];
  endtask

  task automatic ex_idle();
    drive_ex(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  // Sample mid-low-phase, then move to the next negedge (one rising edge in between).
  task automatic step();
    #2;
    compare_out();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0;
    IF_pc = 32'h100;
    ex_idle();
    @(negedge clk);

    // Reset state, and an update coincident with reset must be discarded
    IF_pc = 32'h100; ex_idle();
    push_exp("rst_lookup", 1'b0, 32'h104, 5'd0, 1'b0, 32'h104);
    step();
    IF_pc = 32'h100; drive_ex(1'b1, 1'b1, 1'b1, 32'h100, 32'h80, 1'b1, 32'h104);
    push_exp("rst_upd", 1'b0, 32'h104, 5'd0, 1'b1, 32'h80);
    step();
    reset = 1'b1;
    IF_pc = 32'h100; ex_idle();
    push_exp("post_rst", 1'b0, 32'h104, 5'd0, 1'b0, 32'h104);
    step();

    // Branch at 0x100 taken to 0x80: same-cycle lookup sees the old prediction
    IF_pc = 32'h100; drive_ex(1'b1, 1'b1, 1'b1, 32'h100, 32'h80, 1'b1, 32'h104);
    push_exp("br_alloc_t", 1'b0, 32'h104, 5'd0, 1'b1, 32'h80);
    step();
    IF_pc = 32'h100; drive_ex(1'b1, 1'b1, 1'b1, 32'h100, 32'h80, 1'b1, 32'h80);
    push_exp("br_t2", 1'b1, 32'h80, 5'd0, 1'b0, 32'h104);
    step();
    IF_pc = 32'h100; drive_ex(1'b1, 1'b1, 1'b1, 32'h100, 32'h80, 1'b1, 32'h80);
    push_exp("br_t3_sat", 1'b1, 32'h80, 5'd0, 1'b0, 32'h104);
    step();
    // Counter saturated at 3: one not-taken leaves it predicting taken, the second does not
    IF_pc = 32'h100; drive_ex(1'b1, 1'b1, 1'b1, 32'h100, 32'h80, 1'b0, 32'h80);
    push_exp("br_nt1", 1'b1, 32'h80, 5'd0, 1'b1, 32'h104);
    step();
    IF_pc = 32'h100; drive_ex(1'b1, 1'b1, 1'b1, 32'h100, 32'h80, 1'b0, 32'h80);
    push_exp("br_nt2", 1'b1, 32'h80, 5'd0, 1'b1, 32'h104);
    step();
    IF_pc = 32'h100; ex_idle();
    push_exp("br_weak_nt", 1'b0, 32'h104, 5'd0, 1'b0, 32'h104);
    step();

    // JAL at 0x40 -> 0x200, predicted fall-through
    IF_pc = 32'h40; drive_ex(1'b1, 1'b1, 1'b0, 32'h40, 32'h200, 1'b1, 32'h44);
    push_exp("jal_resolve", 1'b0, 32'h44, 5'd16, 1'b1, 32'h200);
    step();
    IF_pc = 32'h40; ex_idle();
    push_exp("jal_lookup", 1'b1, 32'h200, 5'd16, 1'b0, 32'h44);
    step();

    // Alias of 0x40 with a different tag: no hit; non-control mispredicted taken
    IF_pc = 32'hC0; drive_ex(1'b1, 1'b0, 1'b0, 32'hC0, 32'h999, 1'b0, 32'h200);
    push_exp("alias_add", 1'b0, 32'hC4, 5'd16, 1'b1, 32'hC4);
    step();
    IF_pc = 32'h40; ex_idle();
    push_exp("alias_no_upd", 1'b1, 32'h200, 5'd16, 1'b0, 32'h44);
    step();

    // Not-taken branch allocation starts weakly not-taken
    IF_pc = 32'h20; drive_ex(1'b1, 1'b1, 1'b1, 32'h20, 32'h500, 1'b0, 32'h24);
    push_exp("nt_alloc", 1'b0, 32'h24, 5'd8, 1'b0, 32'h24);
    step();
    IF_pc = 32'h20; ex_idle();
    push_exp("nt_alloc_lkp", 1'b0, 32'h24, 5'd8, 1'b0, 32'h24);
    step();
    IF_pc = 32'h20; drive_ex(1'b1, 1'b1, 1'b1, 32'h20, 32'h500, 1'b1, 32'h24);
    push_exp("nt_then_t", 1'b0, 32'h24, 5'd8, 1'b1, 32'h500);
    step();
    IF_pc = 32'h20; ex_idle();
    push_exp("nt_then_t_lkp", 1'b1, 32'h500, 5'd8, 1'b0, 32'h24);
    step();

    // EX_valid=0 must neither update nor mispredict
    IF_pc = 32'h100; drive_ex(1'b0, 1'b1, 1'b1, 32'h100, 32'h300, 1'b1, 32'h104);
    push_exp("invalid_ex", 1'b0, 32'h104, 5'd0, 1'b0, 32'h104);
    step();
    IF_pc = 32'h100; ex_idle();
    push_exp("invalid_no_upd", 1'b0, 32'h104, 5'd0, 1'b0, 32'h104);
    step();

    // Reset mid-sequence with a coincident JAL update
    reset = 1'b0;
    IF_pc = 32'h40; drive_ex(1'b1, 1'b1, 1'b0, 32'h40, 32'h600, 1'b1, 32'h44);
    push_exp("mid_rst", 1'b0, 32'h44, 5'd16, 1'b1, 32'h600);
    step();
    reset = 1'b1;
    IF_pc = 32'h40; ex_idle();
    push_exp("mid_rst_40", 1'b0, 32'h44, 5'd16, 1'b0, 32'h44);
    step();
    IF_pc = 32'h100; ex_idle();
    push_exp("mid_rst_100", 1'b0, 32'h104, 5'd0, 1'b0, 32'h104);
    step();
    IF_pc = 32'h20; ex_idle();
    push_exp("mid_rst_20", 1'b0, 32'h24, 5'd8, 1'b0, 32'h24);
    step();

    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_predictor_unit.md
BRANCH_PREDICTOR_UNIT -- requirements
Module: branch_predictor_unit

Interface
REQ-001 SHALL have parameter BTB_ENTRIES, default 32, number of BTB/PHT entries, power of two, 4..1024.
REQ-002 SHALL have parameter CNT_WIDTH, default 2, saturating-counter width, 1..4.
REQ-003 SHALL have parameter GHR_WIDTH, default 5, global-history length, 1..log2(BTB_ENTRIES).
REQ-004 SHALL use one clock `clk`; reset is asynchronous and active-low on port `reset`.
REQ-005 Ports (name  direction  width  meaning):
- clk  in  1  clock.
- reset  in  1  async active-low reset.
- IF_pc  in  32  fetch PC.
- pred_taken  out  1  IF prediction taken.
- pred_pc  out  32  predicted next PC.
- pred_idx  out  log2(BTB_ENTRIES)  PHT index used; carried down the pipeline.
- EX_valid  in  1  EX stage holds a live instruction.
- EX_is_ctrl  in  1  EX instruction is BRANCH/JAL/JALR.
- EX_is_branch  in  1  EX instruction is conditional BRANCH.
- EX_pc  in  32  EX instruction PC.
- EX_target  in  32  resolved target (pc+imm or ALU result).
- EX_taken  in  1  resolved taken (bcond, or 1 for JAL/JALR).
- EX_pred_pc  in  32  pred_pc carried from IF.
- EX_pht_idx  in  log2(BTB_ENTRIES)  pred_idx carried from IF.
- mispredict  out  1  redirect required.
- redirect_pc  out  32  corrected PC.
- flush_IF_ID  out  1  flush IF/ID.
- flush_ID_EX  out  1  flush ID/EX.

Function
REQ-006 SHALL form BTB index I = IF_pc[log2(BTB_ENTRIES)+1:2] and tag T = IF_pc[31:log2(BTB_ENTRIES)+2].
REQ-007 SHALL store per BTB entry: valid, tag, 32-bit target, uncond bit; per PHT entry: CNT_WIDTH-bit counter.
REQ-008 SHALL assert hit combinationally when valid[I] and tag[I]==T.
REQ-009 SHALL drive pred_taken = hit && (uncond[I] || counter MSB at pred_idx); pred_pc = pred_taken ? target[I] : IF_pc+4, mod 2^32.
REQ-010 SHALL compute actual = EX_taken ? EX_target : EX_pc+4, and mispredict = EX_valid && (actual != EX_pred_pc), combinationally.
REQ-011 SHALL drive redirect_pc = actual, and flush_IF_ID = flush_ID_EX = mispredict; redirect_pc = IF_pc+4 when mispredict=0.
REQ-012 SHALL detect a non-control instruction predicted taken by BTB aliasing as a mispredict (EX_taken=0, actual=EX_pc+4).
REQ-013 SHALL, on the clk rising edge with EX_valid && EX_is_ctrl, write entry at EX_pc index: valid=1, tag, uncond=!EX_is_branch; target written only when EX_taken.
REQ-014 SHALL update counter at EX_pht_idx for branches: +1 saturating at 2^CNT_WIDTH-1 if taken, -1 saturating at 0 if not.
REQ-015 SHALL, on a branch allocation (tag miss or invalid), set counter to 2^(CNT_WIDTH-1) if taken, else 2^(CNT_WIDTH-1)-1.
REQ-016 SHALL make no table update when EX_valid=0 or EX_is_ctrl=0.
REQ-017 SHALL return pre-update contents when lookup and update hit the same entry in one cycle; the new value is visible the next cycle.
REQ-018 SHALL have lookup latency 0 cycles and update latency 1 edge.

Reset
REQ-019 SHALL, while reset=0, asynchronously clear all valid bits, set all counters to 2^(CNT_WIDTH-1)-1, and clear GHR.
REQ-020 SHALL hold pred_taken=0 and pred_pc=IF_pc+4 during and after reset until the first update; mispredict follows REQ-010.
REQ-021 SHALL discard an update coincident with reset assertion.

Configuration
REQ-022 SHALL, with GSHARE_EN defined, set pred_idx = I XOR zero-extended GHR; the GHR shifts in EX_taken at LSB on each EX_valid && EX_is_branch edge.
REQ-023 SHALL, without GSHARE_EN, set pred_idx = I and contain no GHR registers.

Verification
REQ-024 After reset, IF_pc=0x100 -> pred_taken=0, pred_pc=0x104.
REQ-025 BRANCH at 0x100 resolves taken to 0x80 twice -> next lookup at 0x100 gives pred_taken=1, pred_pc=0x80; counter=3 for CNT_WIDTH=2.
REQ-026 JAL at 0x40 to 0x200, EX_pred_pc=0x44 -> mispredict=1, redirect_pc=0x200, both flushes=1; next lookup at 0x40 gives pred_pc=0x200.
REQ-027 ADD at 0x40+4*BTB_ENTRIES (alias of 0x40, tag differs) -> pred_taken=0; injected EX_pred_pc=0x200 with EX_taken=0 -> mispredict=1, redirect_pc=EX_pc+4.
REQ-028 Same-cycle lookup/update of 0x100 -> old prediction this cycle, new one next cycle; reset mid-sequence -> all predictions revert to pc+4.
